// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the display-word load handshake, the link to the shared
// segment decoder and the display pin drive of one scan controller.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    enable;
    logic                    lz_blank;
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [3:0]              dec_value;
    logic [6:0]              dec_digit;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    // Environment side: load logic, shared decoder and display pins.
    modport master (
        output enable, lz_blank, load_valid, load_data, dec_digit,
        input  load_ready, dec_value, seg, dig_sel, frame_done
    );

    // Scan controller side.
    modport slave (
        input  enable, lz_blank, load_valid, load_data, dec_digit,
        output load_ready, dec_value, seg, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one shared 7-segment decoder across
// NUM_DIGITS common-cathode digits. A double-buffered BCD word feeds one nibble
// per slot to the decoder; each slot starts with BLANK_CYCLES dark cycles so
// segment and digit-select changes never ghost onto a neighbouring digit.
module seg_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CycW  = $clog2(PRESCALE);
    localparam int unsigned WordW = 4 * NUM_DIGITS;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBlank = 2'd1;
    localparam logic [1:0] StDrive = 2'd2;

    localparam logic [IdxW-1:0] IdxLast      = IdxW'(NUM_DIGITS - 1);
    localparam logic [CycW-1:0] CycLast      = CycW'(PRESCALE - 1);
    localparam logic [CycW-1:0] CycBlankLast = CycW'(BLANK_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CycW-1:0]       cyc_q, cyc_d;
    logic [WordW-1:0]      active_q, active_d;
    logic [WordW-1:0]      pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  load_ready_q, load_ready_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [3:0]            dec_value_q, dec_value_d;
    logic                  xfer;
    logic [NUM_DIGITS-1:0] blank_mask;

    // Leading-zero mask: digit i is blankable when it and every higher nibble are zero.
    always_comb begin
        logic zero_above;
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above    = zero_above & (active_q[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above && (i != 0);
        end
    end

    // Scan FSM, slot/cycle counters, double buffer and output next-state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cyc_d        = cyc_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        seg_d        = seg_q;
        dig_sel_d    = dig_sel_q;
        frame_done_d = 1'b0;
        xfer         = 1'b0;

        case (state_q)
            StBlank: begin
                if (!bus.enable) begin
                    state_d   = StIdle;
                    idx_d     = '0;
                    cyc_d     = '0;
                    seg_d     = '0;
                    dig_sel_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    if (cyc_q == CycBlankLast) begin
                        // Segments and digit select switch on the same edge.
                        seg_d     = (bus.lz_blank && blank_mask[idx_q]) ? 7'd0 : bus.dec_digit;
                        dig_sel_d = NUM_DIGITS'(1) << idx_q;
                        state_d   = StDrive;
                    end
                end
            end
            StDrive: begin
                if (!bus.enable) begin
                    state_d   = StIdle;
                    idx_d     = '0;
                    cyc_d     = '0;
                    seg_d     = '0;
                    dig_sel_d = '0;
                end else if (cyc_q == CycLast) begin
                    cyc_d     = '0;
                    dig_sel_d = '0;
                    state_d   = StBlank;
                    if (idx_q == IdxLast) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        xfer         = pend_full_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                // Idle (and recovery from any unused encoding).
                state_d   = bus.enable ? StBlank : StIdle;
                idx_d     = '0;
                cyc_d     = '0;
                seg_d     = '0;
                dig_sel_d = '0;
                xfer      = pend_full_q;
            end
        endcase

        if (xfer) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        // Ready is low whenever pending is full, so a handshake never collides with xfer.
        if (bus.load_valid && load_ready_q) begin
            pend_d      = bus.load_data;
            pend_full_d = 1'b1;
        end
        load_ready_d = !pend_full_d;

        // Look ahead so the decoder input is settled from the first dark cycle of a slot.
        dec_value_d = (state_d == StIdle) ? 4'd0 : active_d[4*idx_d +: 4];
    end

    // State registers with synchronous active-low reset; pending data is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cyc_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            frame_done_q <= 1'b0;
            seg_q        <= '0;
            dig_sel_q    <= '0;
            dec_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cyc_q        <= cyc_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            dec_value_q  <= dec_value_d;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_sel_q;
    assign bus.dec_value  = dec_value_q;
endmodule
